// File: rtl/buffered_ram_pkg.sv
// buffered_ram_pkg: shared FSM encoding, latency limits and byte-lane helpers
// for the buffered RAM with sweep clear.
package buffered_ram_pkg;
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 3;
   localparam int MAXW = 256;
   function automatic int lane_count(input int dw, input int bw);
      return dw / bw;
   endfunction
   // Callers widen their operands to MAXW and cast the result back to their word width.
   function automatic logic [MAXW-1:0] byte_merge(input logic [MAXW-1:0] old_w,
                                                  input logic [MAXW-1:0] new_w,
                                                  input logic [MAXW-1:0] be,
                                                  input int bw);
      logic [MAXW-1:0] r;
      for (int i = 0; i < MAXW; i++) r[i] = be[i / bw] ? new_w[i] : old_w[i];
      return r;
   endfunction
endpackage

// File: rtl/buffered_ram_core.sv
// buffered_ram_core: storage array with byte-lane writes and a registered read
// port; optional same-address bypass returns the merged new word.
module buffered_ram_core
   import buffered_ram_pkg::*;
#(
   parameter int AW  = 4,
   parameter int DW  = 16,
   parameter int BW  = 8,
   parameter int RDW = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          we,
   input  logic [lane_count(DW, BW)-1:0] be,
   input  logic [AW-1:0]                 waddr,
   input  logic [DW-1:0]                 wdata,
   input  logic                          re,
   input  logic [AW-1:0]                 raddr,
   output logic [DW-1:0]                 rdata
);
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] wr_m, rd_m, rd_d;
   assign wr_m = DW'(byte_merge(MAXW'(mem[waddr]), MAXW'(wdata), MAXW'(be), BW));
   assign rd_m = DW'(byte_merge(MAXW'(mem[raddr]), MAXW'(wdata), MAXW'(be), BW));
   assign rd_d = (RDW != 0 && we && waddr == raddr) ? rd_m : mem[raddr];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wr_m;
   // Loads only on accepted reads, so the returned word holds between reads.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rdata <= '0;
      else if (re) rdata <= rd_d;
endmodule

// File: rtl/buffered_ram_clr.sv
// buffered_ram_clr: simple-dual-port RAM with byte enables, configurable read
// latency and a sweep-clear engine that initialises every word.
module buffered_ram_clr
   import buffered_ram_pkg::*;
#(
   parameter int                    p_addresswidth   = 4,
   parameter int                    p_datawidth      = 16,
   parameter int                    p_bytewidth      = 8,
   parameter int                    p_rd_latency     = 2,
   parameter int                    p_rdw_newdata    = 0,
   parameter logic [p_datawidth-1:0] p_clear_value   = '0,
   parameter int                    p_clear_on_reset = 1
) (
   input  logic                                            inclk,
   input  logic                                            inrstn,
   input  logic                                            in_clear,
   output logic                                            out_busy,
   input  logic                                            in_wren,
   input  logic [lane_count(p_datawidth, p_bytewidth)-1:0] in_byteen,
   input  logic [p_addresswidth-1:0]                       in_wraddress,
   input  logic [p_datawidth-1:0]                          in_wrdata,
   input  logic                                            in_rden,
   input  logic [p_addresswidth-1:0]                       in_rdaddress,
   output logic                                            out_rdvalid,
   output logic [p_datawidth-1:0]                          out_rddata
);
   localparam int NB = lane_count(p_datawidth, p_bytewidth);
   localparam int L  = p_rd_latency;
   if (L < LAT_MIN || L > LAT_MAX) begin : g_bad_latency
      $error("p_rd_latency out of range");
   end
   state_e                    state_q, state_d;
   logic [p_addresswidth-1:0] cnt_q, cnt_d;
   logic [p_datawidth-1:0]    core_q;
   logic [L-1:0]              vld_q;
   logic                      rd_acc;
   assign out_busy = state_q == CLEAR;
   assign rd_acc   = !out_busy && in_rden;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (&cnt_q) state_d = IDLE;
      end else if (in_clear) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge inclk or negedge inrstn)
      if (!inrstn) begin
         state_q <= p_clear_on_reset != 0 ? CLEAR : IDLE;
         cnt_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= L'({vld_q, rd_acc});
      end
   // The sweep owns the write port for the whole CLEAR phase.
   buffered_ram_core #(
      .AW (p_addresswidth),
      .DW (p_datawidth),
      .BW (p_bytewidth),
      .RDW(p_rdw_newdata)
   ) u_core (
      .clk  (inclk),
      .rst_n(inrstn),
      .we   (out_busy || in_wren),
      .be   (out_busy ? {NB{1'b1}} : in_byteen),
      .waddr(out_busy ? cnt_q : in_wraddress),
      .wdata(out_busy ? p_clear_value : in_wrdata),
      .re   (rd_acc),
      .raddr(in_rdaddress),
      .rdata(core_q)
   );
   assign out_rdvalid = vld_q[L-1];
   if (L == 1) begin : g_l1
      assign out_rddata = core_q;
   end else begin : g_ln
      logic [p_datawidth-1:0] dat_q [1:L-1];
      always_ff @(posedge inclk or negedge inrstn)
         if (!inrstn) begin
            for (int i = 1; i < L; i++) dat_q[i] <= '0;
         end else begin
            if (vld_q[0]) dat_q[1] <= core_q;
            for (int i = 2; i < L; i++) if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
      assign out_rddata = dat_q[L-1];
   end
endmodule

// File: tb/tb_buffered_ram_clr.sv
// tb_buffered_ram_clr: three buffered_ram_clr instances (L=2/old-data,
// L=1/new-data, L=3/new-data) share one directed stimulus sequence.
module tb_buffered_ram_clr;
   typedef struct {int k; int c; logic [15:0] d;} rec_t;
   logic        clk = 0, rst_n = 0, clr = 0, wren = 0, rden = 0;
   logic [1:0]  be = '0;
   logic [3:0]  wa = '0, ra = '0;
   logic [15:0] wd = '0;
   logic        busy [3];
   logic        vld [3];
   logic [15:0] rdd [3];
   int          lat [3] = '{2, 1, 3};
   int          cyc = 0, tests = 0, fails = 0;
   rec_t        mq [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      for (int k = 0; k < 3; k++) if (vld[k]) mq.push_back('{k, cyc, rdd[k]});

   buffered_ram_clr #(.p_rd_latency(2), .p_rdw_newdata(0), .p_clear_value(16'hA5A5)) u0 (
      .inclk(clk), .inrstn(rst_n), .in_clear(clr), .out_busy(busy[0]), .in_wren(wren),
      .in_byteen(be), .in_wraddress(wa), .in_wrdata(wd), .in_rden(rden),
      .in_rdaddress(ra), .out_rdvalid(vld[0]), .out_rddata(rdd[0]));
   buffered_ram_clr #(.p_rd_latency(1), .p_rdw_newdata(1), .p_clear_value(16'hA5A5)) u1 (
      .inclk(clk), .inrstn(rst_n), .in_clear(clr), .out_busy(busy[1]), .in_wren(wren),
      .in_byteen(be), .in_wraddress(wa), .in_wrdata(wd), .in_rden(rden),
      .in_rdaddress(ra), .out_rdvalid(vld[1]), .out_rddata(rdd[1]));
   buffered_ram_clr #(.p_rd_latency(3), .p_rdw_newdata(1), .p_clear_value(16'hA5A5)) u2 (
      .inclk(clk), .inrstn(rst_n), .in_clear(clr), .out_busy(busy[2]), .in_wren(wren),
      .in_byteen(be), .in_wraddress(wa), .in_wrdata(wd), .in_rden(rden),
      .in_rdaddress(ra), .out_rdvalid(vld[2]), .out_rddata(rdd[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nclk(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s busy u%0d", tag, k), 32'(busy[k]), 32'd1);
         chk($sformatf("%s rdvalid u%0d", tag, k), 32'(vld[k]), 32'd0);
         chk($sformatf("%s rddata u%0d", tag, k), 32'(rdd[k]), 32'h0);
      end
   endtask

   task automatic busy_len(input string tag);
      int n = 0;
      while (busy[0] && n < 40) begin
         n++;
         nclk();
      end
      chk({tag, " busy cycles"}, n, 16);
      chk({tag, " busy u1 low"}, 32'(busy[1]), 32'd0);
      chk({tag, " busy u2 low"}, 32'(busy[2]), 32'd0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
      wren = 1; wa = a; wd = d; be = b;
      nclk();
      wren = 0; be = '0;
   endtask

   task automatic rd_burst(input logic [3:0] a [$]);
      foreach (a[i]) begin
         rden = 1; ra = a[i];
         nclk();
      end
      rden = 0;
   endtask

   // e0: expected words for the old-data instance, e1: for the new-data ones.
   task automatic chk_reads(input string tag, input int c0, input int n,
                            input logic [15:0] e0 [$], input logic [15:0] e1 [$]);
      nclk(5);
      #1;
      for (int k = 0; k < 3; k++) begin
         int j = 0;
         foreach (mq[i]) if (mq[i].k == k) begin
            if (j < n) begin
               chk($sformatf("%s u%0d #%0d cycle", tag, k, j), mq[i].c, c0 + j + lat[k]);
               chk($sformatf("%s u%0d #%0d data", tag, k, j), 32'(mq[i].d),
                   32'(k == 0 ? e0[j] : e1[j]));
            end
            j++;
         end
         chk($sformatf("%s u%0d count", tag, k), j, n);
      end
      mq.delete();
   endtask

   initial begin
      logic [3:0]  aq [$];
      logic [15:0] e0 [$], e1 [$];
      int          c0, n;
      nclk(2);
      chk_reset("reset");
      rst_n = 1;
      busy_len("reset clear");
      aq = {}; e0 = {};
      for (int i = 0; i < 16; i++) begin aq.push_back(4'(i)); e0.push_back(16'hA5A5); end
      c0 = cyc;
      rd_burst(aq);
      chk_reads("clear readback", c0, 16, e0, e0);

      wr(4'd3, 16'h0000, 2'b11);
      wr(4'd3, 16'h1234, 2'b10);
      wr(4'd4, 16'hFFFF, 2'b00);
      c0 = cyc;
      rd_burst('{4'd3, 4'd4});
      e0 = '{16'h1200, 16'hA5A5};
      chk_reads("byteen", c0, 2, e0, e0);

      wr(4'd5, 16'h0000, 2'b11);
      c0 = cyc;
      wren = 1; wa = 4'd5; wd = 16'hBEEF; be = 2'b11; rden = 1; ra = 4'd5;
      nclk();
      wa = 4'd6; wd = 16'h1234; be = 2'b01; ra = 4'd6;
      nclk();
      wren = 0; be = '0; ra = 4'd5;
      nclk();
      rden = 0;
      e0 = '{16'h0000, 16'hA5A5, 16'hBEEF};
      e1 = '{16'hBEEF, 16'hA534, 16'hBEEF};
      chk_reads("rdw", c0, 3, e0, e1);

      for (int i = 0; i < 8; i++) wr(4'(i), 16'h1000 + 16'(i), 2'b11);
      aq = {}; e0 = {};
      for (int i = 0; i < 8; i++) begin aq.push_back(4'(i)); e0.push_back(16'h1000 + 16'(i)); end
      c0 = cyc;
      rd_burst(aq);
      chk_reads("burst", c0, 8, e0, e0);
      for (int k = 0; k < 3; k++) chk($sformatf("hold u%0d", k), 32'(rdd[k]), 32'h1007);

      clr = 1; wren = 1; wa = 4'd9; wd = 16'h7777; be = 2'b11;
      nclk();
      clr = 0; wren = 0;
      n = 0;
      while (busy[0] && n < 40) begin
         wren = 1; wa = 4'd10; wd = 16'h1111; be = 2'b11; rden = 1; ra = 4'd10;
         clr = n == 3;
         n++;
         nclk();
      end
      clr = 0; wren = 0; rden = 0; be = '0;
      chk("gated sweep cycles", n, 16);
      chk_reads("gated no reads", cyc, 0, e0, e0);
      c0 = cyc;
      rd_burst('{4'd9, 4'd10, 4'd0, 4'd15});
      e0 = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
      chk_reads("post clear", c0, 4, e0, e0);

      rden = 1; ra = 4'd1;
      nclk();
      ra = 4'd2;
      @(posedge clk);
      #1;
      rden = 0; rst_n = 0;
      mq.delete();
      nclk();
      chk_reset("mid reset");
      nclk();
      rst_n = 1;
      busy_len("mid reset clear");
      chk_reads("flushed", cyc, 0, e0, e0);

      clr = 1;
      nclk();
      clr = 0;
      nclk(7);
      rst_n = 0;
      nclk();
      rst_n = 1;
      busy_len("sweep restart");
      c0 = cyc;
      rd_burst('{4'd7, 4'd15});
      e0 = '{16'hA5A5, 16'hA5A5};
      chk_reads("final", c0, 2, e0, e0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
